// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA 640x480@60 timing constants, coordinate types and sync decode.
// Used by the sync generator and by the colour/text pixel stages.
package vga_sync_gen_pkg;

    localparam int COORD_W     = 10;
    localparam int FRAME_CNT_W = 8;

    localparam int DEF_CLK_DIV   = 2;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL      = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL      = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic video_on;
        logic hsync_n;
        logic vsync_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{video_on: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

    // Sync pulses are active low: the _n field drops inside [lo, hi].
    function automatic sync_t decode_sync(
        input coord_t x,
        input coord_t y,
        input coord_t x_vis,
        input coord_t y_vis,
        input coord_t hs_lo,
        input coord_t hs_hi,
        input coord_t vs_lo,
        input coord_t vs_hi
    );
        sync_t s;
        s.video_on = (x < x_vis) && (y < y_vis);
        s.hsync_n  = !((x >= hs_lo) && (x <= hs_hi));
        s.vsync_n  = !((y >= vs_lo) && (y <= vs_hi));
        return s;
    endfunction

endpackage

// File: rtl/vga_tick_div.sv
// Pixel-rate divider: counts 0..CLK_DIV-1 and strobes o_tick on the last count.
// The strobe is held low while i_srst is high, including when CLK_DIV = 1.
module vga_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic i_srst,
    output logic o_tick
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic          w_at_last;

    assign w_at_last = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_div_cnt <= '0;
        end else if (w_at_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    assign o_tick = !i_srst && w_at_last;

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: pixel counters, sync/video decode, frame strobe.
// Optional frame counter output is built only when VGA_FRAME_CNT_EN is defined.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

    localparam coord_t H_LAST   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   w_p_tick;
    logic   w_h_wrap;
    logic   w_frame_start;
    coord_t r_h_cnt;
    coord_t r_v_cnt;
    coord_t w_h_next;
    coord_t w_v_next;
    sync_t  w_sync_next;
    sync_t  r_sync;

    vga_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk    (clk),
        .i_srst (reset),
        .o_tick (w_p_tick)
    );

    assign w_h_wrap      = (r_h_cnt == H_LAST);
    assign w_frame_start = w_p_tick && w_h_wrap && (r_v_cnt == V_LAST);

    always_comb begin
        w_h_next = r_h_cnt;
        w_v_next = r_v_cnt;
        if (w_p_tick) begin
            if (w_h_wrap) begin
                w_h_next = '0;
                w_v_next = (r_v_cnt == V_LAST) ? coord_t'(0) : r_v_cnt + coord_t'(1);
            end else begin
                w_h_next = r_h_cnt + coord_t'(1);
            end
        end
    end

    // Decoding the next-state counters lets sync/video register on the same edge as the counters.
    assign w_sync_next = decode_sync(w_h_next, w_v_next, H_VIS, V_VIS,
                                     HS_START, HS_END, VS_START, VS_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_sync  <= SYNC_IDLE;
        end else begin
            r_h_cnt <= w_h_next;
            r_v_cnt <= w_v_next;
            r_sync  <= w_sync_next;
        end
    end

    assign p_tick      = w_p_tick;
    assign pixel_x     = r_h_cnt;
    assign pixel_y     = r_v_cnt;
    assign video_on    = r_sync.video_on;
    assign hsync       = r_sync.hsync_n;
    assign vsync       = r_sync.vsync_n;
    assign frame_start = w_frame_start;

`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (w_frame_start) begin
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
